mem_req_ctrl: RTL and testbench

Request controller sitting directly upstream of the 16x32 single-port memory; sole driver of its enable/address/write-data inputs and sole consumer of its read data/valid.
- Accepts write/read commands over a valid/ready interface and buffers them in a command FIFO.
- Issues commands to the memory strictly in order, one per cycle.
- Tags and returns read data over a valid/ready response interface, with credit-based back-pressure so no read response is ever dropped.

---
 rtl/mem_req_pkg.sv | 24 ++
 rtl/mem_req_fifo.sv | 62 ++++++
 rtl/mem_req_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request controller.
package mem_req_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int STAT_W = 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_rsp_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO with count-based full/empty and async active-high reset.
// Pushes while full and pops while empty are dropped internally.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap so non power-of-two depths also work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage array: written on push, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= nxt(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of a 16x32 single-port memory.
// Commands queue in a FIFO and issue in order, one per cycle; read returns
// are tagged and buffered in a response FIFO guarded by a credit check.
// Optional build macro MEM_REQ_CTRL_STATS_EN adds saturating write/read
// issue counters (o_wr_count / o_rd_count).
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int ADDR_W    = mem_req_pkg::ADDR_W,
  parameter int DATA_W    = mem_req_pkg::DATA_W,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out,
  input  logic              i_mem_valid,
  output logic              o_busy,
  output logic              o_proto_err
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]       o_wr_count,
  output logic [15:0]       o_rd_count
`endif
);

  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int RCW = $clog2(RSP_DEPTH + 1);

  mem_cmd_t          w_cmd_in;
  mem_cmd_t          w_cmd_head;
  mem_rsp_t          w_rsp_in;
  mem_rsp_t          w_rsp_head;
  logic              w_cmd_push;
  logic              w_cmd_full;
  logic              w_cmd_empty;
  logic [CCW-1:0]    w_cmd_count;
  logic              w_rsp_pop;
  logic              w_rsp_full;
  logic              w_rsp_empty;
  logic [RCW-1:0]    w_rsp_count;
  logic [RCW:0]      w_rsp_used;
  logic              w_rd_ok;
  logic              w_issue;
  logic              w_wr_issue;
  logic              w_rd_issue;
  logic              w_unused;

  logic              r_rdy;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_tag;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_proto_err;

  assign w_unused = ^{w_cmd_count, w_rsp_full};

  // ---------------- command side ----------------
  assign o_cmd_ready = r_rdy & ~w_cmd_full;
  assign w_cmd_push  = i_cmd_valid & o_cmd_ready;
  assign w_cmd_in    = '{we: i_cmd_we, addr: i_cmd_addr, data: i_cmd_wdata};

  mem_req_fifo #(.WIDTH($bits(mem_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_cmd_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_issue),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  // Read credit: entries held plus the read in flight, less the entry the
  // consumer takes this cycle. Crediting the same-cycle pop is what lets
  // back-to-back reads run at one per cycle with only two response slots.
  assign w_rsp_pop  = ~w_rsp_empty & i_rsp_ready;
  assign w_rsp_used = {1'b0, w_rsp_count} + {{RCW{1'b0}}, r_inflight}
                    - {{RCW{1'b0}}, w_rsp_pop};
  assign w_rd_ok    = (w_rsp_used < (RCW+1)'(RSP_DEPTH));

  assign w_issue    = ~w_cmd_empty & (w_cmd_head.we | w_rd_ok);
  assign w_wr_issue = w_issue & w_cmd_head.we;
  assign w_rd_issue = w_issue & ~w_cmd_head.we;

  // Idle cycles hold the last address so the memory's dummy read is harmless.
  assign o_mem_en      = w_wr_issue;
  assign o_mem_address = w_issue ? w_cmd_head.addr : r_last_addr;
  assign o_mem_data_in = w_wr_issue ? w_cmd_head.data : '0;

  // ---------------- response side ----------------
  assign w_rsp_in = '{addr: r_tag, data: i_mem_data_out};

  mem_req_fifo #(.WIDTH($bits(mem_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_data  (w_rsp_in),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

  assign o_rsp_valid = ~w_rsp_empty;
  assign o_rsp_addr  = w_rsp_head.addr;
  assign o_rsp_data  = w_rsp_head.data;
  assign o_busy      = ~w_cmd_empty | r_inflight;
  assign o_proto_err = r_proto_err;

  // Ready gating, in-flight tag, last address and sticky protocol error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdy       <= 1'b0;
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_last_addr <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rdy      <= 1'b1;
      r_inflight <= w_rd_issue;
      if (w_rd_issue) r_tag <= w_cmd_head.addr;
      if (w_issue)    r_last_addr <= w_cmd_head.addr;
      if (r_inflight & ~i_mem_valid) r_proto_err <= 1'b1;
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  // Saturating counts of issued writes and reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_wr_issue) r_wr_count <= sat_inc(r_wr_count);
      if (w_rd_issue) r_rd_count <= sat_inc(r_rd_count);
    end
  end

  assign o_wr_count = r_wr_count;
  assign o_rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 16x32 memory.
module tb_mem_req_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [3:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [3:0]  o_rsp_addr;
  logic        o_mem_en;
  logic [3:0]  o_mem_address;
  logic [31:0] o_mem_data_in, i_mem_data_out;
  logic        i_mem_valid, o_busy, o_proto_err;
`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] wr_cnt, rd_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [3:0] a; logic [31:0] d; } exp_t;
  exp_t        sb[$];
  logic [31:0] sh [16];

  mem_req_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_addr(o_rsp_addr),
    .o_mem_en(o_mem_en), .o_mem_address(o_mem_address), .o_mem_data_in(o_mem_data_in),
    .i_mem_data_out(i_mem_data_out), .i_mem_valid(i_mem_valid),
    .o_busy(o_busy), .o_proto_err(o_proto_err)
`ifdef MEM_REQ_CTRL_STATS_EN
    , .o_wr_count(wr_cnt), .o_rd_count(rd_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Memory model: write on en, 1-cycle read latency, valid unless killed.
  logic [31:0] mem [16];
  logic [31:0] mem_q;
  logic        kill_valid = 1'b0;
  always @(posedge i_clk) begin
    if (o_mem_en) mem[o_mem_address] <= o_mem_data_in;
    mem_q <= mem[o_mem_address];
  end
  assign i_mem_data_out = mem_q;
  assign i_mem_valid    = ~kill_valid;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every accepted response is compared with the scoreboard head.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", {63'd0, o_rsp_valid}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_addr", {60'd0, o_rsp_addr}, {60'd0, e.a});
        chk("rsp_data", {32'd0, o_rsp_data}, {32'd0, e.d});
      end
    end
  end

  // Issue one command; returns 1 time unit after the accepting edge.
  task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = a; i_cmd_wdata = d;
    @(negedge i_clk);
    while (!o_cmd_ready && n < 50) begin @(negedge i_clk); n++; end
    if (!o_cmd_ready) chk("cmd_accept_timeout", {63'd0, o_cmd_ready}, 64'd1);
    else begin
      @(posedge i_clk); #1;
      if (we) sh[a] = d;
      else    sb.push_back('{a: a, d: sh[a]});
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge i_clk); n++; end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_rsp_ready = 0;
    repeat (2) @(negedge i_clk);

    // 1: reset values, ready after release
    chk("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("rst_mem_en",    {63'd0, o_mem_en}, 64'd0);
    chk("rst_mem_addr",  {60'd0, o_mem_address}, 64'd0);
    chk("rst_mem_din",   {32'd0, o_mem_data_in}, 64'd0);
    chk("rst_busy",      {63'd0, o_busy}, 64'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    chk("rel_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    chk("rel_busy",      {63'd0, o_busy}, 64'd0);
    chk("rel_proto_err", {63'd0, o_proto_err}, 64'd0);
    chk("rel_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);

    // 2: write 3 then read 3, cycle-exact
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 4'd3; i_cmd_wdata = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("t2_ready", {63'd0, o_cmd_ready}, 64'd1);
    @(posedge i_clk); #1;
    sh[3] = 32'hDEADBEEF;
    i_cmd_we = 0; sb.push_back('{a: 4'd3, d: 32'hDEADBEEF});
    @(negedge i_clk);
    chk("t2_wr_en",   {63'd0, o_mem_en}, 64'd1);
    chk("t2_wr_addr", {60'd0, o_mem_address}, 64'd3);
    chk("t2_wr_data", {32'd0, o_mem_data_in}, 64'hDEADBEEF);
    @(posedge i_clk); #1 i_cmd_valid = 0;
    @(negedge i_clk);
    chk("t2_rd_en",   {63'd0, o_mem_en}, 64'd0);
    chk("t2_rd_addr", {60'd0, o_mem_address}, 64'd3);
    chk("t2_rsp_T2",  {63'd0, o_rsp_valid}, 64'd0);
    @(negedge i_clk);
    chk("t2_rsp_T3",  {63'd0, o_rsp_valid}, 64'd0);
    chk("t2_busy_T3", {63'd0, o_busy}, 64'd1);
    @(negedge i_clk);
    chk("t2_rsp_T4",  {63'd0, o_rsp_valid}, 64'd1);
    chk("t2_busy_T4", {63'd0, o_busy}, 64'd0);
    chk("t2_idle_addr", {60'd0, o_mem_address}, 64'd3);
    chk("t2_idle_din",  {32'd0, o_mem_data_in}, 64'd0);
    drain("t2_drain");

    // 3: back-pressure fills the response and command FIFOs
    @(posedge i_clk); #1 i_rsp_ready = 1'b0;
    send(1, 4'd5, 32'h55);
    send(0, 4'd3, 0); send(0, 4'd5, 0);
    send(0, 4'd3, 0); send(0, 4'd5, 0); send(0, 4'd5, 0); send(0, 4'd3, 0);
    @(negedge i_clk);
    chk("t3_cmd_full",  {63'd0, o_cmd_ready}, 64'd0);
    chk("t3_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
    chk("t3_stall_en",  {63'd0, o_mem_en}, 64'd0);
    chk("t3_stall_addr",{60'd0, o_mem_address}, 64'd5);
    chk("t3_busy",      {63'd0, o_busy}, 64'd1);
    repeat (4) @(negedge i_clk);
    chk("t3_still_full", {63'd0, o_cmd_ready}, 64'd0);
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    drain("t3_drain");
    repeat (2) @(negedge i_clk);
    chk("t3_idle_busy", {63'd0, o_busy}, 64'd0);

    // 4: fill memory with addr*3, then 16 back-to-back reads
    @(posedge i_clk); #1;
    for (int i = 0; i < 16; i++) send(1, 4'(i), 32'(i * 3));
    fork
      begin
        for (int j = 0; j < 16; j++) send(0, 4'(j), 0);
      end
      begin
        int n, c;
        n = 0; c = 0;
        @(negedge i_clk);
        while (!o_rsp_valid && n < 100) begin @(negedge i_clk); n++; end
        while (o_rsp_valid && c < 40) begin c++; @(negedge i_clk); end
        chk("t4_consecutive", 64'(c), 64'd16);
      end
    join
    drain("t4_drain");

    // 5: reset with a read in flight and two commands queued
    @(posedge i_clk); #1 i_rsp_ready = 1'b0;
    send(0, 4'd0, 0); send(0, 4'd1, 0);
    send(0, 4'd2, 0); send(0, 4'd4, 0); send(0, 4'd6, 0);
    repeat (2) @(negedge i_clk);
    chk("t5_rsp_held", {63'd0, o_rsp_valid}, 64'd1);
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("t5_rd_issue_addr", {60'd0, o_mem_address}, 64'd2);
    @(posedge i_clk); #1 i_rsp_ready = 1'b0;
    chk("t5_busy_inflight", {63'd0, o_busy}, 64'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("t5_rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
    chk("t5_rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("t5_rst_mem_en",    {63'd0, o_mem_en}, 64'd0);
    chk("t5_rst_mem_addr",  {60'd0, o_mem_address}, 64'd0);
    chk("t5_rst_mem_din",   {32'd0, o_mem_data_in}, 64'd0);
    chk("t5_rst_busy",      {63'd0, o_busy}, 64'd0);
    sb.delete();
    @(posedge i_clk); #1 i_rst = 1'b0; i_rsp_ready = 1'b1;
    begin
      int c;
      c = 0;
      repeat (10) begin @(negedge i_clk); if (o_rsp_valid) c++; end
      chk("t5_no_rsp_after_rst", 64'(c), 64'd0);
    end
    chk("t5_busy_after", {63'd0, o_busy}, 64'd0);
    chk("t5_ready_after", {63'd0, o_cmd_ready}, 64'd1);

    // 6: missing memory valid on a read return
    @(posedge i_clk); #1 kill_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("t6_idle_valid_ignored", {63'd0, o_proto_err}, 64'd0);
    @(posedge i_clk); #1 kill_valid = 1'b0;
    send(0, 4'd7, 0);
    @(posedge i_clk); #1 kill_valid = 1'b1;
    @(negedge i_clk);
    chk("t6_err_before_edge", {63'd0, o_proto_err}, 64'd0);
    @(posedge i_clk); #1 kill_valid = 1'b0;
    @(negedge i_clk);
    chk("t6_err_set", {63'd0, o_proto_err}, 64'd1);
    drain("t6_drain");
    send(1, 4'd7, 32'h77); send(0, 4'd7, 0);
    drain("t6_drain2");
    chk("t6_err_sticky", {63'd0, o_proto_err}, 64'd1);
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk("t6_err_cleared", {63'd0, o_proto_err}, 64'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
